// File: rtl/multi_key_debounce_sched.sv
// multi_key_debounce_sched
// Debounces KEY_CNT raw key inputs using one shared glitch timer. Keys whose
// synchronised level differs from their debounced level are granted the timer
// in round-robin order; a new level is committed only after it has been
// stable for G+1 consecutive samples, G = max(1, CLK_FREQ_MHZ*GLITCH_TIME_NS/1000).
//
// Optional feature macro: KEY_RELEASE_STB_EN
//   defined   : release commits pulse key_released_stb_o[idx]
//   undefined : key_released_stb_o is tied to 0
//
// Ports
//   clk_i              : clock, rising edge
//   rst_n_i            : synchronous active-low reset
//   key_i              : raw asynchronous keys, 1 = pressed
//   key_state_o        : debounced level per key
//   key_pressed_stb_o  : one-cycle strobe on a committed 0->1 transition
//   key_released_stb_o : one-cycle strobe on a committed 1->0 transition
//   busy_o             : timer allocated (TIMING or COMMIT)
//   grant_idx_o        : index of the key currently owning the timer
module multi_key_debounce_sched #(
   parameter int unsigned CLK_FREQ_MHZ   = 150,
   parameter int unsigned GLITCH_TIME_NS = 100,
   parameter int unsigned KEY_CNT        = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [KEY_CNT-1:0]  key_i,
   output logic [KEY_CNT-1:0]  key_state_o,
   output logic [KEY_CNT-1:0]  key_pressed_stb_o,
   output logic [KEY_CNT-1:0]  key_released_stb_o,
   output logic                busy_o,
   output logic [((KEY_CNT > 1) ? $clog2(KEY_CNT) : 1)-1:0] grant_idx_o
);

   localparam int unsigned G_RAW = (CLK_FREQ_MHZ * GLITCH_TIME_NS) / 1000;
   localparam int unsigned G     = (G_RAW < 1) ? 1 : G_RAW;
   localparam int unsigned TW    = $clog2(G + 1);
   localparam int unsigned IW    = (KEY_CNT > 1) ? $clog2(KEY_CNT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TIMING = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [KEY_CNT-1:0]  sync1, key_s;
   logic [KEY_CNT-1:0]  key_state, key_state_nxt;
   logic [KEY_CNT-1:0]  press_stb, press_nxt;
   logic [IW-1:0]       idx, idx_nxt;
   logic [IW-1:0]       rr, rr_nxt;
   logic [IW-1:0]       idx_inc;
   logic [IW-1:0]       pick;
   logic                found;
   logic                tgt, tgt_nxt;
   logic [TW-1:0]       timer, timer_nxt;
   logic                busy, busy_nxt;
   logic [KEY_CNT-1:0]  mismatch;

`ifdef KEY_RELEASE_STB_EN
   logic [KEY_CNT-1:0]  rel_stb, rel_nxt;
`endif

   assign mismatch = key_s ^ key_state;

   // Successor of the granted index, wrapping at KEY_CNT-1
   assign idx_inc = (idx == IW'(KEY_CNT - 1)) ? '0 : idx + IW'(1);

   // Round-robin search: first mismatching key at or after rr
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int unsigned i = 0; i < KEY_CNT; i++) begin
         int unsigned s;
         s = 32'(rr) + i;
         if (s >= KEY_CNT) s = s - KEY_CNT;
         if (!found && mismatch[IW'(s)]) begin
            found = 1'b1;
            pick  = IW'(s);
         end
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      tgt_nxt       = tgt;
      timer_nxt     = timer;
      rr_nxt        = rr;
      key_state_nxt = key_state;
      press_nxt     = '0;
`ifdef KEY_RELEASE_STB_EN
      rel_nxt       = '0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               idx_nxt   = pick;
               tgt_nxt   = key_s[pick];
               timer_nxt = TW'(G - 1);
               state_nxt = TIMING;
            end
         end
         TIMING: begin
            if (key_s[idx] != tgt) begin
               // glitch: give up without touching outputs
               state_nxt = IDLE;
               rr_nxt    = idx_inc;
            end else if (timer == '0) begin
               state_nxt = COMMIT;
               rr_nxt    = idx_inc;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         COMMIT: begin
            key_state_nxt[idx] = tgt;
            if (tgt) begin
               press_nxt[idx] = 1'b1;
            end
`ifdef KEY_RELEASE_STB_EN
            else begin
               rel_nxt[idx] = 1'b1;
            end
`endif
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == TIMING) || (state_nxt == COMMIT);
   end

   // State, synchroniser and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state     <= IDLE;
         sync1     <= '0;
         key_s     <= '0;
         key_state <= '0;
         press_stb <= '0;
         idx       <= '0;
         rr        <= '0;
         tgt       <= 1'b0;
         timer     <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sync1     <= key_i;
         key_s     <= sync1;
         key_state <= key_state_nxt;
         press_stb <= press_nxt;
         idx       <= idx_nxt;
         rr        <= rr_nxt;
         tgt       <= tgt_nxt;
         timer     <= timer_nxt;
         busy      <= busy_nxt;
      end
   end

`ifdef KEY_RELEASE_STB_EN
   // Release strobe register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rel_stb <= '0;
      end else begin
         rel_stb <= rel_nxt;
      end
   end
   assign key_released_stb_o = rel_stb;
`else
   assign key_released_stb_o = '0;
`endif

   assign key_state_o       = key_state;
   assign key_pressed_stb_o = press_stb;
   assign busy_o            = busy;
   assign grant_idx_o       = idx;

endmodule
